// File: rtl/aemb_wb_dma_if.sv
// Wishbone classic bus bundle between the DMA initiator and a memory responder.
// Signal names keep the core's dwb port naming so existing responders map directly.
interface aemb_wb_dma_if #(
  parameter int ASIZ = 16
);
  logic [ASIZ-1:0] wb_adr_o;
  logic [31:0]     wb_dat_o;
  logic [31:0]     wb_dat_i;
  logic            wb_we_o;
  logic            wb_stb_o;
  logic [3:0]      wb_sel_o;
  logic            wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/aemb_wb_dma.sv
// Word-granular memory-to-memory copy / fill engine on a Wishbone classic port.
// Each bus phase is followed by one idle gap cycle so a registered-echo ack never lands stale.
module aemb_wb_dma #(
  parameter int ASIZ = 16
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  input  logic [ASIZ-1:0] cfg_src_i,
  input  logic [ASIZ-1:0] cfg_dst_i,
  input  logic [13:0]     cfg_len_i,
  input  logic            cfg_fill_i,
  input  logic [31:0]     cfg_pat_i,
  input  logic            start_i,
  input  logic            abort_i,
  output logic            busy_o,
  output logic            done_o,
  aemb_wb_dma_if.master   wb
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RGAP, S_WR, S_WGAP, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [ASIZ-1:0] src_cur, dst_cur;
  logic [13:0]     rem;
  logic            fill_q;
  logic [31:0]     pat_q, data_q;

  logic            ack_ok;
  logic            bus_nxt;
  logic [ASIZ-1:0] src_eff, dst_eff;
  logic            fill_eff;
  logic [31:0]     pat_eff;

  // NOTE: a registered output keeps its value when no branch assigns it, so
  // only the combinational block needs every signal defaulted up front.
  always_comb begin
    state_nxt = state;
    ack_ok    = wb.wb_stb_o & wb.wb_ack_i;
    unique case (state)
      S_IDLE: begin
        if (start_i) begin
          if (cfg_len_i == 14'd0) state_nxt = S_DONE;
          else                    state_nxt = cfg_fill_i ? S_WR : S_RD;
        end
      end
      S_RD: begin
        if (abort_i)     state_nxt = S_IDLE;
        else if (ack_ok) state_nxt = S_RGAP;
      end
      S_RGAP: state_nxt = abort_i ? S_IDLE : S_WR;
      S_WR: begin
        if (abort_i)     state_nxt = S_IDLE;
        else if (ack_ok) state_nxt = S_WGAP;
      end
      S_WGAP: begin
        if (abort_i)           state_nxt = S_IDLE;
        else if (rem == 14'd0) state_nxt = S_DONE;
        else                   state_nxt = fill_q ? S_WR : S_RD;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Leaving IDLE the latches are not loaded yet, so the first address/data
  // comes straight from the configuration inputs.
  always_comb begin
    bus_nxt  = (state_nxt == S_RD) || (state_nxt == S_WR);
    src_eff  = (state == S_IDLE) ? cfg_src_i  : src_cur;
    dst_eff  = (state == S_IDLE) ? cfg_dst_i  : dst_cur;
    fill_eff = (state == S_IDLE) ? cfg_fill_i : fill_q;
    pat_eff  = (state == S_IDLE) ? cfg_pat_i  : pat_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      src_cur     <= '0;
      dst_cur     <= '0;
      rem         <= '0;
      fill_q      <= 1'b0;
      pat_q       <= '0;
      data_q      <= '0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_sel_o <= '0;
      wb.wb_adr_o <= '0;
      wb.wb_dat_o <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      if (state == S_IDLE && start_i && cfg_len_i != 14'd0) begin
        src_cur <= cfg_src_i;
        dst_cur <= cfg_dst_i;
        rem     <= cfg_len_i;
        fill_q  <= cfg_fill_i;
        pat_q   <= cfg_pat_i;
      end

      if (state == S_RD && ack_ok && !abort_i)
        data_q <= wb.wb_dat_i;

      // An ack coinciding with abort is dropped: the word is not counted.
      if (state == S_WR && ack_ok && !abort_i) begin
        src_cur <= src_cur + ASIZ'(4);
        dst_cur <= dst_cur + ASIZ'(4);
        rem     <= rem - 14'd1;
      end

      wb.wb_stb_o <= bus_nxt;
      wb.wb_we_o  <= (state_nxt == S_WR);
      wb.wb_sel_o <= bus_nxt ? 4'hF : 4'h0;
      if (state_nxt == S_RD) begin
        wb.wb_adr_o <= {src_eff[ASIZ-1:2], 2'b00};
      end else if (state_nxt == S_WR) begin
        wb.wb_adr_o <= {dst_eff[ASIZ-1:2], 2'b00};
        wb.wb_dat_o <= fill_eff ? pat_eff : data_q;
      end

      busy_o <= (state_nxt != S_IDLE);
      done_o <= (state_nxt == S_DONE);
    end
  end

endmodule
